// File: rtl/incr_pkg.sv
// Shared definitions for the round-robin increment arbiter:
// FSM state type, default datapath width and the grant-selection helper.
package incr_pkg;

    localparam int INCR_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } incr_state_e;

    // Round-robin pick between two requesters. last1 set means requester 1
    // was granted most recently, so requester 0 wins a tie.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last1);
        logic [1:0] win;
        case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11: begin
                if (last1) begin
                    win = 2'b01;
                end else begin
                    win = 2'b10;
                end
            end
            default: win = 2'b00;
        endcase
        return win;
    endfunction

endpackage

// File: rtl/incrementer.sv
// Combinational +1 unit shared by both requesters.
// Macro INCR_ARB_OVF_EN: when defined the carry-out is produced; otherwise
// cout is a constant 0 and no carry logic exists.
module incrementer
    import incr_pkg::*;
#(
    parameter int WIDTH = INCR_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y,
    output logic             cout
);

`ifdef INCR_ARB_OVF_EN
    assign {cout, y} = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
`else
    assign y    = a + {{(WIDTH-1){1'b0}}, 1'b1};
    assign cout = 1'b0;
`endif

endmodule

// File: rtl/incr_arbiter.sv
// Two-requester round-robin arbiter in front of a single shared incrementer.
// A winner is picked in IDLE, its operand is incremented in BUSY, the result
// is shown in DONE and done_o pulses in the following cycle.
// Macro INCR_ARB_OVF_EN: enables the carry-out on ovf_o (otherwise ovf_o = 0).
module incr_arbiter
    import incr_pkg::*;
#(
    parameter int WIDTH = INCR_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_i,
    input  logic [WIDTH-1:0] in0_i,
    input  logic [WIDTH-1:0] in1_i,
    output logic [1:0]       gnt_o,
    output logic [1:0]       done_o,
    output logic [WIDTH-1:0] out_o,
    output logic             ovf_o
);

    incr_state_e      state_r, state_s;
    logic [1:0]       gnt_r, gnt_s;
    logic [1:0]       done_r, done_s;
    logic [1:0]       win_s;
    logic [WIDTH-1:0] opnd_r, opnd_s;
    logic [WIDTH-1:0] out_r, out_s;
    logic [WIDTH-1:0] sum_s;
    logic             last1_r, last1_s;
    logic             ovf_r, ovf_s;
    logic             carry_s;

    incrementer #(.WIDTH(WIDTH)) u_inc (
        .a    (opnd_r),
        .y    (sum_s),
        .cout (carry_s)
    );

    // Next-state and next-output logic for the IDLE/BUSY/DONE sequence.
    always_comb begin
        state_s = state_r;
        gnt_s   = gnt_r;
        done_s  = 2'b00;
        opnd_s  = opnd_r;
        out_s   = out_r;
        ovf_s   = ovf_r;
        last1_s = last1_r;
        win_s   = rr_pick(req_i, last1_r);
        case (state_r)
            IDLE: begin
                if (req_i != 2'b00) begin
                    state_s = BUSY;
                    gnt_s   = win_s;
                    last1_s = win_s[1];
                    if (win_s[0]) begin
                        opnd_s = in0_i;
                    end else begin
                        opnd_s = in1_i;
                    end
                end else begin
                    gnt_s = 2'b00;
                end
            end
            BUSY: begin
                state_s = DONE;
                out_s   = sum_s;
                ovf_s   = carry_s;
            end
            DONE: begin
                state_s = IDLE;
                gnt_s   = 2'b00;
                done_s  = gnt_r;
            end
            default: begin
                state_s = IDLE;
                gnt_s   = 2'b00;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            gnt_r   <= 2'b00;
            done_r  <= 2'b00;
            opnd_r  <= {WIDTH{1'b0}};
            out_r   <= {WIDTH{1'b0}};
            ovf_r   <= 1'b0;
            last1_r <= 1'b1;
        end else begin
            state_r <= state_s;
            gnt_r   <= gnt_s;
            done_r  <= done_s;
            opnd_r  <= opnd_s;
            out_r   <= out_s;
            ovf_r   <= ovf_s;
            last1_r <= last1_s;
        end
    end

    assign gnt_o  = gnt_r;
    assign done_o = done_r;
    assign out_o  = out_r;
    assign ovf_o  = ovf_r;

endmodule

// File: tb/tb_incr_arbiter.sv
// Self-checking bench for incr_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_incr_arbiter;

    localparam int W = 4;
`ifdef INCR_ARB_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req;
    logic [W-1:0] in0, in1;
    logic [1:0]   gnt, done;
    logic [W-1:0] out;
    logic         ovf;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    incr_arbiter #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .req_i  (req),
        .in0_i  (in0),
        .in1_i  (in1),
        .gnt_o  (gnt),
        .done_o (done),
        .out_o  (out),
        .ovf_o  (ovf)
    );

    // Reference model: a transaction starts at edge st, occupies edges
    // st..st+2, grant is visible for two cycles, done for the third.
    int unsigned  ncyc = 0;
    int unsigned  st = 0;
    bit           act = 1'b0;
    bit           last1 = 1'b1;
    logic [1:0]   who = 2'b00;
    int           op = 0;
    logic [1:0]   exp_gnt = 2'b00;
    logic [1:0]   exp_done = 2'b00;
    logic [W-1:0] exp_out = '0;
    logic         exp_ovf = 1'b0;

    task automatic model_step();
        int v;
        ncyc++;
        if (rst) begin
            act = 1'b0; last1 = 1'b1;
            exp_gnt = 2'b00; exp_done = 2'b00; exp_out = '0; exp_ovf = 1'b0;
        end else begin
            if (act && ncyc >= st + 3) act = 1'b0;
            if (!act && req != 2'b00) begin
                act = 1'b1;
                st  = ncyc;
                if (req == 2'b11) who = last1 ? 2'b01 : 2'b10;
                else              who = req;
                last1 = (who == 2'b10);
                op = (who == 2'b01) ? int'(in0) : int'(in1);
            end
            exp_gnt  = (act && (ncyc - st) <= 1) ? who : 2'b00;
            exp_done = (act && (ncyc - st) == 2) ? who : 2'b00;
            if (act && (ncyc - st) == 1) begin
                v = op + 1;
                exp_out = v[W-1:0];
                exp_ovf = OVF_ON ? v[W] : 1'b0;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 2'b00; in0 = '0; in1 = '0;
        for (int i = 0; i < 2; i++) begin
            cyc();
            total++;
            if (gnt !== 2'b00 || done !== 2'b00 || out !== 4'b0000 || ovf !== 1'b0) begin
                bad++;
                $display("FAIL reset_state gnt=%b done=%b out=%b ovf=%b want 00 00 0000 0", gnt, done, out, ovf);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            total++;
            if (gnt !== 2'b00 || done !== 2'b00 || out !== 4'b0000) begin
                bad++;
                $display("FAIL idle_after_reset cyc=%0d gnt=%b done=%b out=%b want 00 00 0000", i, gnt, done, out);
            end
        end
    endtask

    task automatic test_single();
        req = 2'b01; in0 = 4'b0011;
        cyc();
        req = 2'b00;
        total++;
        if (gnt !== 2'b01 || done !== 2'b00) begin
            bad++; $display("FAIL single_busy gnt=%b done=%b want 01 00", gnt, done);
        end
        cyc();
        total++;
        if (gnt !== 2'b01 || done !== 2'b00) begin
            bad++; $display("FAIL single_done_state gnt=%b done=%b want 01 00", gnt, done);
        end
        cyc();
        total++;
        if (gnt !== 2'b00 || done !== 2'b01 || out !== 4'b0100) begin
            bad++; $display("FAIL single_result gnt=%b done=%b out=%b want 00 01 0100", gnt, done, out);
        end
        cyc();
        total++;
        if (done !== 2'b00) begin
            bad++; $display("FAIL single_pulse_width done=%b want 00", done);
        end
    endtask

    task automatic test_contention();
        logic [1:0]   dseq [$];
        logic [W-1:0] oseq [$];
        rst = 1'b1; cyc(); rst = 1'b0;
        req = 2'b11; in0 = 4'b0101; in1 = 4'b1000;
        for (int i = 0; i < 10; i++) begin
            cyc();
            total++;
            if (gnt !== exp_gnt || done !== exp_done) begin
                bad++; $display("FAIL contention_model cyc=%0d gnt=%b done=%b want %b %b", i, gnt, done, exp_gnt, exp_done);
            end
            if (done !== 2'b00) begin
                dseq.push_back(done);
                oseq.push_back(out);
            end
        end
        total++;
        if (dseq.size() < 3) begin
            bad++; $display("FAIL contention_count got=%0d want 3", dseq.size());
        end else if (dseq[0] !== 2'b01 || dseq[1] !== 2'b10 || dseq[2] !== 2'b01 ||
                     oseq[0] !== 4'b0110 || oseq[1] !== 4'b1001 || oseq[2] !== 4'b0110) begin
            bad++;
            $display("FAIL contention_order got %b/%b %b/%b %b/%b want 01/0110 10/1001 01/0110",
                     dseq[0], oseq[0], dseq[1], oseq[1], dseq[2], oseq[2]);
        end
        req = 2'b00;
        for (int i = 0; i < 4; i++) cyc();
    endtask

    task automatic test_wrap();
        logic exp_o;
        exp_o = OVF_ON;
        req = 2'b10; in1 = 4'b1111;
        cyc();
        req = 2'b00;
        cyc();
        cyc();
        total++;
        if (done !== 2'b10 || out !== 4'b0000 || ovf !== exp_o) begin
            bad++; $display("FAIL wrap done=%b out=%b ovf=%b want 10 0000 %b", done, out, ovf, exp_o);
        end
        cyc();
    endtask

    task automatic test_reset_abort();
        req = 2'b01; in0 = 4'b1110;
        cyc();
        total++;
        if (gnt !== 2'b01) begin
            bad++; $display("FAIL abort_grant gnt=%b want 01", gnt);
        end
        rst = 1'b1; req = 2'b00;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (gnt !== 2'b00 || done !== 2'b00 || out !== 4'b0000 || ovf !== 1'b0) begin
                bad++; $display("FAIL abort cyc=%0d gnt=%b done=%b out=%b ovf=%b want 00 00 0000 0", i, gnt, done, out, ovf);
            end
            cyc();
        end
    endtask

    task automatic test_withdraw();
        req = 2'b01; in0 = 4'b0000;
        cyc();
        req = 2'b00;
        cyc();
        cyc();
        total++;
        if (done !== 2'b01 || out !== 4'b0001) begin
            bad++; $display("FAIL withdraw done=%b out=%b want 01 0001", done, out);
        end
        cyc();
        total++;
        if (gnt !== 2'b00 || done !== 2'b00) begin
            bad++; $display("FAIL withdraw_idle gnt=%b done=%b want 00 00", gnt, done);
        end
    endtask

    task automatic test_random();
        logic [1:0] nreq;
        for (int i = 0; i < 400; i++) begin
            rst  = ($urandom_range(0, 59) == 0);
            nreq = 2'($urandom_range(0, 3));
            if (!(nreq[0] && req[0])) in0 = 4'($urandom_range(0, 15));
            if (!(nreq[1] && req[1])) in1 = 4'($urandom_range(0, 15));
            req = nreq;
            cyc();
            total++;
            if (gnt !== exp_gnt || done !== exp_done) begin
                bad++; $display("FAIL random_ctl cyc=%0d gnt=%b done=%b want %b %b", i, gnt, done, exp_gnt, exp_done);
            end
            if (exp_done != 2'b00) begin
                total++;
                if (out !== exp_out || ovf !== exp_ovf) begin
                    bad++; $display("FAIL random_data cyc=%0d out=%b ovf=%b want %b %b", i, out, ovf, exp_out, exp_ovf);
                end
            end
        end
        rst = 1'b0; req = 2'b00;
        for (int i = 0; i < 4; i++) cyc();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_wrap();
        test_reset_abort();
        test_withdraw();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
